// File: rtl/multi_key_debouncer.sv
// N-channel push-button debouncer: 2-flop sync, per-channel stability counter, clean level plus press/release pulses.
// Latency: a clean input edge reaches key_level and its pulse 2 + STABLE_CNT clk cycles later when sample_en is held high.
// No backpressure: pulses are single-cycle and unbuffered. Optional long-press detection is built when DEBOUNCE_LONGPRESS_EN is defined.
module multi_key_debouncer #(
   parameter int N          = 4,
   parameter int CNT_W      = 16,
   parameter int STABLE_CNT = 500,
   parameter bit KEY_IDLE   = 1'b1,
   parameter int LONG_CNT   = 1000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sample_en,
   input  logic [N-1:0] key_in,
   output logic [N-1:0] key_level,
   output logic [N-1:0] key_press,
   output logic [N-1:0] key_release,
   output logic [N-1:0] long_press
);

   // Counter value on which a pending level is accepted (counter starts at 0).
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

   // Reject parameter combinations the counters cannot represent.
   if (N < 1 || N > 32) begin : g_bad_n
      $error("multi_key_debouncer: N must be 1..32");
   end
   if (STABLE_CNT < 1 || STABLE_CNT > (2 ** CNT_W) - 1) begin : g_bad_stable
      $error("multi_key_debouncer: STABLE_CNT must be 1..2^CNT_W-1");
   end
   if (LONG_CNT < 1 || LONG_CNT > (2 ** CNT_W) - 1) begin : g_bad_long
      $error("multi_key_debouncer: LONG_CNT must fit in CNT_W bits");
   end

   logic [N-1:0]            sync_a;
   logic [N-1:0]            sync_b;
   logic [N-1:0][CNT_W-1:0] cnt;
   logic [N-1:0][CNT_W-1:0] cnt_nxt;
   logic [N-1:0]            level_nxt;
   logic [N-1:0]            press_nxt;
   logic [N-1:0]            release_nxt;

   // Two-stage synchroniser, clocked every cycle independent of sample_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= {N{KEY_IDLE}};
         sync_b <= {N{KEY_IDLE}};
      end else begin
         sync_a <= key_in;
         sync_b <= sync_a;
      end
   end

   // Per-channel stability counting: any agreement with the current level clears the count,
   // a disagreement advances it on sample ticks, and the final tick accepts the new level.
   always_comb begin
      cnt_nxt     = cnt;
      level_nxt   = key_level;
      press_nxt   = '0;
      release_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (sync_b[i] == key_level[i]) begin
            cnt_nxt[i] = '0;
         end else if (sample_en) begin
            if (cnt[i] == STABLE_LAST) begin
               cnt_nxt[i]   = '0;
               level_nxt[i] = sync_b[i];
               if (sync_b[i] != KEY_IDLE) begin
                  press_nxt[i] = 1'b1;
               end else begin
                  release_nxt[i] = 1'b1;
               end
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Counter, debounced level and registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         key_level   <= {N{KEY_IDLE}};
         key_press   <= '0;
         key_release <= '0;
      end else begin
         cnt         <= cnt_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
      end
   end

`ifdef DEBOUNCE_LONGPRESS_EN
   // Hold counter value at which long_press fires; the counter then parks here until release.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CNT - 1);

   logic [N-1:0][CNT_W-1:0] hold;
   logic [N-1:0][CNT_W-1:0] hold_nxt;
   logic [N-1:0]            long_nxt;

   // Count sample ticks while the debounced level is active; restart on every fresh press.
   always_comb begin
      hold_nxt = hold;
      long_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (key_level[i] == KEY_IDLE || key_press[i]) begin
            hold_nxt[i] = '0;
         end else if (sample_en && hold[i] != HOLD_LAST) begin
            hold_nxt[i] = hold[i] + 1'b1;
            long_nxt[i] = (hold_nxt[i] == HOLD_LAST);
         end
      end
   end

   // Hold counters and the registered long-press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= '0;
         long_press <= '0;
      end else begin
         hold       <= hold_nxt;
         long_press <= long_nxt;
      end
   end
`else
   assign long_press = {N{1'b0}};
`endif

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Bench for multi_key_debouncer: directed timing steps plus random keys against a behavioural model.
// Outputs are sampled 1 ns after each rising edge; the model advances on the same edge.
// Long-press expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_multi_key_debouncer;

   localparam int N          = 4;
   localparam int CNT_W      = 8;
   localparam int STABLE_CNT = 10;
   localparam int LONG_CNT   = 40;
   localparam bit KEY_IDLE   = 1'b1;
`ifdef DEBOUNCE_LONGPRESS_EN
   localparam bit LP_ON = 1'b1;
`else
   localparam bit LP_ON = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         sample_en;
   logic [N-1:0] key_in;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] long_press;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: pin history, accepted level, ticks spent disagreeing, ticks held.
   int m_s1 [N];
   int m_s2 [N];
   int m_lvl [N];
   int m_run [N];
   int m_hold [N];
   bit m_press [N];
   bit m_rel [N];
   bit m_long [N];

   multi_key_debouncer #(
      .N(N), .CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT), .KEY_IDLE(KEY_IDLE), .LONG_CNT(LONG_CNT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .key_in(key_in),
      .key_level(key_level), .key_press(key_press), .key_release(key_release),
      .long_press(long_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_s1[c] = int'(KEY_IDLE); m_s2[c] = int'(KEY_IDLE); m_lvl[c] = int'(KEY_IDLE);
         m_run[c] = 0; m_hold[c] = 0;
         m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
      end
   endtask

   // One clock edge of the reference: a new level is accepted once the synchronised pin has
   // disagreed with it for STABLE_CNT sample ticks in a row.
   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < N; c++) begin
            bit lp = 1'b0;
            bit p  = 1'b0;
            bit r  = 1'b0;
            if (m_lvl[c] == int'(KEY_IDLE) || m_press[c]) begin
               m_hold[c] = 0;
            end else if (sample_en) begin
               m_hold[c] = m_hold[c] + 1;
               lp = LP_ON && (m_hold[c] == LONG_CNT - 1);
            end
            if (m_s2[c] != m_lvl[c]) begin
               if (sample_en) begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] == STABLE_CNT) begin
                     m_lvl[c] = m_s2[c];
                     m_run[c] = 0;
                     if (m_lvl[c] != int'(KEY_IDLE)) p = 1'b1; else r = 1'b1;
                  end
               end
            end else begin
               m_run[c] = 0;
            end
            m_press[c] = p; m_rel[c] = r; m_long[c] = lp;
            m_s2[c] = m_s1[c];
            m_s1[c] = int'(key_in[c]);
         end
      end
   endtask

   task automatic compare_model();
      logic [N-1:0] el, ep, er, elp;
      for (int c = 0; c < N; c++) begin
         el[c] = m_lvl[c][0]; ep[c] = m_press[c]; er[c] = m_rel[c]; elp[c] = m_long[c];
      end
      chk("model_level", 32'(key_level), 32'(el));
      chk("model_press", 32'(key_press), 32'(ep));
      chk("model_release", 32'(key_release), 32'(er));
      chk("model_long", 32'(long_press), 32'(elp));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   // Apply a clean input change and demand the pulses exactly 12 edges later, for one cycle only.
   task automatic edge_check(input logic [N-1:0] nk, input logic [N-1:0] ep, input logic [N-1:0] er);
      key_in = nk;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k < 12) begin
            chk("pre_press", 32'(key_press), 32'h0);
            chk("pre_release", 32'(key_release), 32'h0);
         end else begin
            chk("press_at_12", 32'(key_press), 32'(ep));
            chk("release_at_12", 32'(key_release), 32'(er));
         end
      end
      step();
      chk("press_one_cycle", 32'(key_press), 32'h0);
      chk("release_one_cycle", 32'(key_release), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; sample_en = 1'b1; key_in = 4'hF;
      model_reset();
      #23;
      chk("reset_level", 32'(key_level), 32'hF);
      chk("reset_press", 32'(key_press), 32'h0);
      chk("reset_release", 32'(key_release), 32'h0);
      chk("reset_long", 32'(long_press), 32'h0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("quiet_after_reset", 32'({key_press, key_release}), 32'h0);
      end

      // Clean fall on key 0: level and press exactly 12 edges later, other channels untouched.
      edge_check(4'hE, 4'h1, 4'h0);
      chk("key0_level", 32'(key_level), 32'hE);

      // Key 1 bounces with 4-cycle runs: nothing accepted, then a clean settle at 0.
      for (int c = 0; c < 60; c++) begin
         key_in[1] = ((c / 4) % 2 == 0) ? 1'b1 : 1'b0;
         step();
         chk("bounce_press", 32'(key_press), 32'h0);
         chk("bounce_level", 32'(key_level), 32'hE);
      end
      edge_check(4'hC, 4'h2, 4'h0);

      // Sample tick 1 clk in 3: ticks on edges 3,6,...,30 so acceptance lands on edge 30.
      key_in[2] = 1'b0;
      for (int j = 1; j <= 30; j++) begin
         sample_en = (j % 3 == 0);
         step();
         chk("slow_tick_press", 32'(key_press), (j == 30) ? 32'h4 : 32'h0);
      end
      sample_en = 1'b1;
      step();
      chk("slow_tick_one_cycle", 32'(key_press), 32'h0);
      chk("slow_tick_level", 32'(key_level), 32'h8);

      // Simultaneous events on several channels.
      edge_check(4'hF, 4'h0, 4'h7);
      edge_check(4'h0, 4'hF, 4'h0);
      edge_check(4'hF, 4'h0, 4'hF);

      // Long hold on key 0: single pulse 40 ticks after the press, no repeat while held.
      edge_check(4'hE, 4'h1, 4'h0);
      for (int k = 2; k <= 40; k++) begin
         step();
         chk("long_timing", 32'(long_press), (LP_ON && k == 40) ? 32'h1 : 32'h0);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         chk("long_no_repeat", 32'(long_press), 32'h0);
      end

      // Reset mid-hold and mid-count on key 3: immediate return to idle, no stray pulse after.
      key_in = 4'h6;
      for (int k = 0; k < 5; k++) step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_level", 32'(key_level), 32'hF);
      chk("midreset_press", 32'(key_press), 32'h0);
      chk("midreset_release", 32'(key_release), 32'h0);
      chk("midreset_long", 32'(long_press), 32'h0);
      key_in = 4'hF;
      for (int k = 0; k < 3; k++) step();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("post_reset_quiet", 32'({key_press, key_release, long_press}), 32'h0);
      end

      // Random bouncing keys and sample ticks against the model.
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 15) == 0) key_in[c] = ~key_in[c];
         end
         sample_en = ($urandom_range(0, 3) != 0);
         step();
         chk("press_release_exclusive", 32'(key_press & key_release), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
